sram_rw_array_ext: RTL and testbench
====================================

// Module: sram_rw_array_ext
// PURPOSE
// - Parametrised single-port (RW0) SRAM macro replacing the fixed-size per-array BRAM wrappers
//   behind the cache data/meta arrays.
// - Adds: generic width/depth/mask granularity, configurable read latency (1 or 2),
//   read-during-write mode, read-valid strobe, and a post-reset zero-initialisation sweep
//   so cache arrays start clean without relying on FPGA init files.
// - Memory is inferred (block RAM); no vendor IP instance.
// PARAMETERS
// - ADDR_W      12   address width
// - DEPTH       4096 number of words, <= 2**ADDR_W
// - DATA_W      256  word width
// - MASK_W      4    write-mask lanes; DATA_W % MASK_W == 0, LANE_W = DATA_W/MASK_W
// - READ_LAT    1    read latency in cycles, 1 or 2 (2 adds an output register)
// - RDW_MODE    0    read-during-write output: 0 = NO_CHANGE (rdata holds), 1 = READ_FIRST (old word)
// - INIT_EN     1    1 = zero-fill all DEPTH words after reset; 0 = no sweep
// PORTS
// - RW0_clk     in   1        clock; all logic on rising edge
// - reset       in   1        asynchronous, active-high reset
// - RW0_en      in   1        access enable
// - RW0_wmode   in   1        1 = write, 0 = read (qualified by RW0_en)
// - RW0_addr    in   ADDR_W   word address
// - RW0_wdata   in   DATA_W   write data
// - RW0_wmask   in   MASK_W   lane i writes RW0_wdata[i*LANE_W +: LANE_W]
// - RW0_rdata   out  DATA_W   read data; holds value between reads
// - RW0_rvalid  out  1        1-cycle pulse when RW0_rdata carries new read data
// - init_busy   out  1        1 while the zero-init sweep runs; requests ignored
// BEHAVIOUR
// - Clock/reset: single clock RW0_clk; reset asynchronous, active-high. Reset values:
//   RW0_rdata=0, RW0_rvalid=0, pipeline regs=0, init_busy=INIT_EN, init counter=0.
//   Memory array contents are not reset directly.
// - FSM {INIT, READY}: reset -> INIT if INIT_EN else READY.
//   - INIT: each cycle writes all-zero word at counter, counter++. After writing DEPTH-1,
//     next state READY and init_busy falls; sweep takes exactly DEPTH cycles.
//   - Reset asserted mid-sweep restarts at address 0.
// - While init_busy=1, RW0_en is ignored: no write, no read, no rvalid; RW0_rdata holds.
// - Accepted access = READY & RW0_en.
// - Read (RW0_wmode=0): word at RW0_addr appears on RW0_rdata, with RW0_rvalid=1, exactly
//   READ_LAT cycles after the accepting edge. Back-to-back reads fully pipelined, one per
//   cycle. RW0_rdata unchanged when no read completes.
// - Write (RW0_wmode=1): masked lanes updated at the accepting edge; unmasked lanes retain
//   old data. RW0_wmask==0 is a legal no-op.
//   - RDW_MODE=0: no read result, no rvalid.
//   - RDW_MODE=1: pre-write word returned with rvalid after READ_LAT.
// - Read of an address written on a prior cycle returns new data (no stale-read window).
// - Out of range, RW0_addr >= DEPTH: writes dropped; reads return 0 with rvalid=1.
// - READ_LAT=2: stage-1 data and valid flow to stage 2 every cycle (no stall); a read in
//   flight when reset asserts is discarded.
// - Illegal parameters (READ_LAT not 1/2, DATA_W % MASK_W != 0, DEPTH > 2**ADDR_W) are
//   caught by an elaboration-time $error.
// TESTING
// - Reset then idle, INIT_EN=1, DEPTH=4096: init_busy=1 for exactly 4096 cycles, then 0;
//   reads of addr 0, 0x7FF and 0xFFF return 0.
// - Write addr 0x010, wdata = 256'h{8{32'hA5A5_5A5A}}, wmask=4'b0101, then read 0x010:
//   lanes 0 and 2 = pattern, lanes 1 and 3 = 0; rvalid 1 cycle after accept (READ_LAT=1)
//   or 2 cycles after (READ_LAT=2).
// - Reads of addr 1,2,3 on consecutive cycles: three consecutive rvalid pulses, data in
//   order; rdata holds the addr-3 word afterwards.
// - RDW_MODE=1: write 0xFF..FF over known 0x11..11 at addr 5 -> rdata = 0x11..11 with
//   rvalid; RDW_MODE=0 -> no rvalid, rdata unchanged.
// - Assert reset at sweep cycle 100, release: sweep restarts from 0 (init_busy high for
//   4096 more cycles); requests issued during the sweep cause no writes and no rvalid.
// - DEPTH=3000, ADDR_W=12: write to 0xC00 is dropped; read of 0xC00 returns 0 with rvalid.

Source files
------------

// File: rtl/sram_rw_array_ext.sv
// sram_rw_array_ext: parametrised single-port masked SRAM with read latency 1/2 and post-reset zero sweep
module sram_rw_array_ext #(
  parameter int ADDR_W   = 12,
  parameter int DEPTH    = 4096,
  parameter int DATA_W   = 256,
  parameter int MASK_W   = 4,
  parameter int READ_LAT = 1,
  parameter int RDW_MODE = 0,
  parameter int INIT_EN  = 1
) (
  input  logic              RW0_clk,
  input  logic              reset,
  input  logic              RW0_en,
  input  logic              RW0_wmode,
  input  logic [ADDR_W-1:0] RW0_addr,
  input  logic [DATA_W-1:0] RW0_wdata,
  input  logic [MASK_W-1:0] RW0_wmask,
  output logic [DATA_W-1:0] RW0_rdata,
  output logic              RW0_rvalid,
  output logic              init_busy
);
  localparam int LANE_W = DATA_W / MASK_W;
  typedef enum logic {INIT, READY} state_t;
  state_t state, state_d;
  logic [ADDR_W-1:0] cnt, cnt_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd1;
  logic rv1, in_range, acc, wr, rd;
  if (!(READ_LAT == 1 || READ_LAT == 2) || DATA_W % MASK_W != 0 || 64'(DEPTH) > (64'd1 << ADDR_W)) begin : g_bad
    $error("sram_rw_array_ext: illegal parameter combination");
  end
  assign init_busy = state == INIT;
  assign in_range = 32'(RW0_addr) < DEPTH;
  assign acc = !init_busy && RW0_en;
  assign wr = acc && RW0_wmode && in_range;
  assign rd = acc && (!RW0_wmode || RDW_MODE != 0);
  always_comb begin
    cnt_d = init_busy ? cnt + 1'b1 : cnt;
    state_d = (init_busy && cnt == ADDR_W'(DEPTH - 1)) ? READY : state;
  end
  always_ff @(posedge RW0_clk or posedge reset) begin
    if (reset) begin
      state <= INIT_EN != 0 ? INIT : READY;
      cnt <= '0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
    end
  end
  // Array kept reset-free so it maps onto block RAM; the sweep provides the clean start.
  always_ff @(posedge RW0_clk) begin
    if (init_busy) mem[cnt] <= '0;
    else if (wr)
      for (int i = 0; i < MASK_W; i++)
        if (RW0_wmask[i]) mem[RW0_addr][i*LANE_W +: LANE_W] <= RW0_wdata[i*LANE_W +: LANE_W];
  end
  always_ff @(posedge RW0_clk or posedge reset) begin
    if (reset) begin
      rd1 <= '0;
      rv1 <= 1'b0;
    end else begin
      rv1 <= rd;
      if (rd) rd1 <= in_range ? mem[RW0_addr] : '0;
    end
  end
  if (READ_LAT == 2) begin : g_l2
    logic [DATA_W-1:0] rd2;
    logic rv2;
    always_ff @(posedge RW0_clk or posedge reset) begin
      if (reset) begin
        rd2 <= '0;
        rv2 <= 1'b0;
      end else begin
        rd2 <= rd1;
        rv2 <= rv1;
      end
    end
    assign RW0_rdata = rd2;
    assign RW0_rvalid = rv2;
  end else begin : g_l1
    assign RW0_rdata = rd1;
    assign RW0_rvalid = rv1;
  end
endmodule

// File: tb/tb_sram_rw_array_ext.sv
// tb_sram_rw_array_ext: directed checks of two configurations (4096x256 lat1 no-change, 3000-deep lat2 read-first)
module tb_sram_rw_array_ext;
  logic clk = 0, reset = 1, en = 0, wmode = 0;
  logic [11:0] addr = '0;
  logic [255:0] wdata = '0;
  logic [3:0] wmask = '0;
  logic [255:0] rdata_a, rdata_b;
  logic rv_a, rv_b, busy_a, busy_b;
  int n_chk = 0, n_fail = 0;
  localparam logic [255:0] PAT = {8{32'hA5A5_5A5A}};
  localparam logic [255:0] EXP_M = {64'h0, 64'hA5A5_5A5A_A5A5_5A5A, 64'h0, 64'hA5A5_5A5A_A5A5_5A5A};
  localparam logic [255:0] W1 = {32{8'h01}};
  localparam logic [255:0] W2 = {32{8'h02}};
  localparam logic [255:0] W3 = {32{8'h03}};
  localparam logic [255:0] ONES11 = {64{4'h1}};
  localparam logic [255:0] ALL1 = {256{1'b1}};
  always #5 clk = ~clk;
  sram_rw_array_ext dut_a (
    .RW0_clk(clk), .reset(reset), .RW0_en(en), .RW0_wmode(wmode), .RW0_addr(addr),
    .RW0_wdata(wdata), .RW0_wmask(wmask), .RW0_rdata(rdata_a), .RW0_rvalid(rv_a), .init_busy(busy_a));
  sram_rw_array_ext #(.DEPTH(3000), .READ_LAT(2), .RDW_MODE(1)) dut_b (
    .RW0_clk(clk), .reset(reset), .RW0_en(en), .RW0_wmode(wmode), .RW0_addr(addr),
    .RW0_wdata(wdata), .RW0_wmask(wmask), .RW0_rdata(rdata_b), .RW0_rvalid(rv_b), .init_busy(busy_b));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drv(input logic e, input logic w, input logic [11:0] a, input logic [255:0] d, input logic [3:0] m);
    en = e;
    wmode = w;
    addr = a;
    wdata = d;
    wmask = m;
  endtask
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    int ca, cb;
    logic rv_seen;
    step();
    step();
    chk("rst_rdata_a", rdata_a, '0);
    chk("rst_rvalid_a", rv_a, 0);
    chk("rst_busy_a", busy_a, 1);
    chk("rst_busy_b", busy_b, 1);
    reset = 0;
    ca = 0;
    cb = 0;
    for (int i = 0; i < 5000 && (busy_a || busy_b); i++) begin
      ca += int'(busy_a);
      cb += int'(busy_b);
      step();
    end
    chk("sweep_len_a", ca, 4096);
    chk("sweep_len_b", cb, 3000);
    drv(1, 0, 12'h000, '0, 4'h0);
    step();
    chk("rd0_rv_a", rv_a, 1);
    chk("rd0_a", rdata_a, '0);
    chk("rd0_rv_b_early", rv_b, 0);
    drv(1, 0, 12'h7FF, '0, 4'h0);
    step();
    chk("rd7ff_a", rdata_a, '0);
    chk("rd0_rv_b", rv_b, 1);
    drv(1, 0, 12'hFFF, '0, 4'h0);
    step();
    chk("rdfff_rv_a", rv_a, 1);
    chk("rdfff_a", rdata_a, '0);
    drv(0, 0, 12'h000, '0, 4'h0);
    step();
    chk("idle_rv_a", rv_a, 0);
    chk("rdfff_rv_b", rv_b, 1);
    chk("rdfff_b", rdata_b, '0);
    drv(1, 1, 12'h010, PAT, 4'b0101);
    step();
    chk("wr_norv_a", rv_a, 0);
    drv(1, 0, 12'h010, '0, 4'h0);
    step();
    chk("mask_rv_a", rv_a, 1);
    chk("mask_a", rdata_a, EXP_M);
    chk("rdw_old_rv_b", rv_b, 1);
    chk("rdw_old_b", rdata_b, '0);
    drv(0, 0, 12'h000, '0, 4'h0);
    step();
    chk("mask_hold_a", rdata_a, EXP_M);
    chk("mask_b", rdata_b, EXP_M);
    step();
    chk("mask_rv_end_b", rv_b, 0);
    drv(1, 1, 12'd1, W1, 4'hF);
    step();
    drv(1, 1, 12'd2, W2, 4'hF);
    step();
    drv(1, 1, 12'd3, W3, 4'hF);
    step();
    drv(1, 1, 12'd5, ONES11, 4'hF);
    step();
    chk("wr_hold_a", rdata_a, EXP_M);
    drv(0, 0, 12'h000, '0, 4'h0);
    step();
    step();
    drv(1, 0, 12'd1, '0, 4'h0);
    step();
    chk("b2b1_a", rdata_a, W1);
    drv(1, 0, 12'd2, '0, 4'h0);
    step();
    chk("b2b2_rv_a", rv_a, 1);
    chk("b2b2_a", rdata_a, W2);
    chk("b2b1_b", rdata_b, W1);
    drv(1, 0, 12'd3, '0, 4'h0);
    step();
    chk("b2b3_a", rdata_a, W3);
    chk("b2b2_b", rdata_b, W2);
    drv(0, 0, 12'h000, '0, 4'h0);
    step();
    chk("b2b_end_rv_a", rv_a, 0);
    chk("b2b_hold_a", rdata_a, W3);
    chk("b2b3_rv_b", rv_b, 1);
    chk("b2b3_b", rdata_b, W3);
    drv(1, 1, 12'd5, ALL1, 4'hF);
    step();
    chk("nc_rv_a", rv_a, 0);
    chk("nc_hold_a", rdata_a, W3);
    drv(0, 0, 12'h000, '0, 4'h0);
    step();
    chk("nc_hold2_a", rdata_a, W3);
    chk("rf_rv_b", rv_b, 1);
    chk("rf_b", rdata_b, ONES11);
    drv(1, 0, 12'd5, '0, 4'h0);
    step();
    chk("new5_a", rdata_a, ALL1);
    drv(0, 0, 12'h000, '0, 4'h0);
    step();
    chk("new5_b", rdata_b, ALL1);
    drv(1, 1, 12'hC00, PAT, 4'hF);
    step();
    drv(1, 0, 12'hC00, '0, 4'h0);
    step();
    chk("c00_a", rdata_a, PAT);
    chk("oor_rdw_rv_b", rv_b, 1);
    chk("oor_rdw_b", rdata_b, '0);
    drv(0, 0, 12'h000, '0, 4'h0);
    step();
    chk("oor_rd_rv_b", rv_b, 1);
    chk("oor_rd_b", rdata_b, '0);
    reset = 1;
    step();
    reset = 0;
    for (int i = 0; i < 100; i++) step();
    reset = 1;
    #1;
    chk("mid_rst_busy_a", busy_a, 1);
    chk("mid_rst_rdata_a", rdata_a, '0);
    step();
    reset = 0;
    ca = 0;
    cb = 0;
    rv_seen = 0;
    for (int i = 0; i < 5000 && (busy_a || busy_b); i++) begin
      drv(busy_b, i[0], 12'd7, ALL1, 4'hF);
      ca += int'(busy_a);
      cb += int'(busy_b);
      step();
      rv_seen = rv_seen | rv_a | rv_b;
    end
    drv(0, 0, 12'h000, '0, 4'h0);
    chk("resweep_len_a", ca, 4096);
    chk("resweep_len_b", cb, 3000);
    chk("sweep_no_rv", rv_seen, 0);
    drv(1, 0, 12'd7, '0, 4'h0);
    step();
    chk("sweep_nowr_rv_a", rv_a, 1);
    chk("sweep_nowr_a", rdata_a, '0);
    drv(1, 0, 12'h010, '0, 4'h0);
    step();
    chk("rezero_a", rdata_a, '0);
    chk("sweep_nowr_b", rdata_b, '0);
    drv(0, 0, 12'h000, '0, 4'h0);
    step();
    chk("rezero_b", rdata_b, '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
